// File: rtl/rvfi_trace_gen.sv
// rtl/rvfi_trace_gen.sv - RVFI trace producer merging issue operands with retirement results
//
// Purpose: buffers per-instruction issue data (pc, insn, source register
// addresses and operand values) in order, then merges the oldest entry with
// the writeback/memory results when it retires. One registered RVFI packet
// is emitted per retired instruction, tagged with a 64-bit order counter.
//
// Ports:
//   g_clk, g_resetn            clock, asynchronous active-low reset
//   iss_*                      issue side: iss_valid pushes one entry
//   ret_*                      retire side: ret_valid pops the oldest entry
//   flush                      discard all entries not retired this cycle
//   rvfi_*                     registered trace packet, valid one cycle after ret_valid
//   err_overflow/underflow     sticky protocol errors (push when full / pop when empty)
module rvfi_trace_gen #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  input  logic              iss_valid,
  input  logic [XLEN-1:0]   iss_pc,
  input  logic [31:0]       iss_insn,
  input  logic [4:0]        iss_rs1_addr,
  input  logic [4:0]        iss_rs2_addr,
  input  logic [4:0]        iss_rs3_addr,
  input  logic [XLEN-1:0]   iss_rs1_rdata,
  input  logic [XLEN-1:0]   iss_rs2_rdata,
  input  logic [XLEN-1:0]   iss_rs3_rdata,
  input  logic              ret_valid,
  input  logic              ret_trap,
  input  logic              ret_intr,
  input  logic [4:0]        ret_rd_addr,
  input  logic [XLEN-1:0]   ret_rd_wdata,
  input  logic [XLEN-1:0]   ret_pc_wdata,
  input  logic [XLEN-1:0]   ret_mem_addr,
  input  logic [XLEN-1:0]   ret_mem_wdata,
  input  logic [XLEN-1:0]   ret_mem_rdata,
  input  logic [XLEN/8-1:0] ret_mem_rmask,
  input  logic [XLEN/8-1:0] ret_mem_wmask,
  input  logic              flush,
  output logic              rvfi_valid,
  output logic [63:0]       rvfi_order,
  output logic [31:0]       rvfi_insn,
  output logic              rvfi_trap,
  output logic              rvfi_intr,
  output logic              rvfi_halt,
  output logic [4:0]        rvfi_rs1_addr,
  output logic [4:0]        rvfi_rs2_addr,
  output logic [4:0]        rvfi_rs3_addr,
  output logic [4:0]        rvfi_rd_addr,
  output logic [XLEN-1:0]   rvfi_rs1_rdata,
  output logic [XLEN-1:0]   rvfi_rs2_rdata,
  output logic [XLEN-1:0]   rvfi_rs3_rdata,
  output logic [XLEN-1:0]   rvfi_rd_wdata,
  output logic [XLEN-1:0]   rvfi_pc_rdata,
  output logic [XLEN-1:0]   rvfi_pc_wdata,
  output logic [XLEN-1:0]   rvfi_mem_addr,
  output logic [XLEN-1:0]   rvfi_mem_wdata,
  output logic [XLEN-1:0]   rvfi_mem_rdata,
  output logic [XLEN/8-1:0] rvfi_mem_rmask,
  output logic [XLEN/8-1:0] rvfi_mem_wmask,
  output logic              err_overflow,
  output logic              err_underflow
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Entry storage; contents need no reset because count gates every read.
  logic [XLEN-1:0] buf_pc    [DEPTH];
  logic [31:0]     buf_insn  [DEPTH];
  logic [4:0]      buf_rs1_a [DEPTH];
  logic [4:0]      buf_rs2_a [DEPTH];
  logic [4:0]      buf_rs3_a [DEPTH];
  logic [XLEN-1:0] buf_rs1_d [DEPTH];
  logic [XLEN-1:0] buf_rs2_d [DEPTH];
  logic [XLEN-1:0] buf_rs3_d [DEPTH];

  logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
  logic [AW:0]   count, count_after, count_nxt;
  logic          do_pop, do_push, underflow_evt, overflow_evt;
  logic [63:0]   order_cnt;

  // Event ordering within a cycle: retire pops the head, flush then empties
  // what is left, and only then is the issue considered. That makes a flush
  // cycle's issue (the redirect target) always fit.
  always_comb begin
    do_pop        = ret_valid && (count != '0);
    underflow_evt = ret_valid && (count == '0);
    count_after   = flush ? '0 : (count - (AW+1)'(do_pop));
    do_push       = iss_valid && (count_after != FULL_CNT);
    overflow_evt  = iss_valid && !do_push;
    rd_ptr_nxt    = flush ? wr_ptr : (rd_ptr + AW'(do_pop));
    wr_ptr_nxt    = wr_ptr + AW'(do_push);
    count_nxt     = count_after + (AW+1)'(do_push);
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      wr_ptr <= wr_ptr_nxt;
      count  <= count_nxt;
    end
  end

  // When full with a simultaneous pop, wr_ptr == rd_ptr; the packet register
  // samples the old head before this write lands, so no bypass is needed.
  always_ff @(posedge g_clk) begin
    if (do_push) begin
      buf_pc[wr_ptr]    <= iss_pc;
      buf_insn[wr_ptr]  <= iss_insn;
      buf_rs1_a[wr_ptr] <= iss_rs1_addr;
      buf_rs2_a[wr_ptr] <= iss_rs2_addr;
      buf_rs3_a[wr_ptr] <= iss_rs3_addr;
      buf_rs1_d[wr_ptr] <= iss_rs1_rdata;
      buf_rs2_d[wr_ptr] <= iss_rs2_rdata;
      buf_rs3_d[wr_ptr] <= iss_rs3_rdata;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      rvfi_valid     <= 1'b0;
      rvfi_order     <= '0;
      order_cnt      <= '0;
      rvfi_insn      <= '0;
      rvfi_trap      <= 1'b0;
      rvfi_intr      <= 1'b0;
      rvfi_rs1_addr  <= '0;
      rvfi_rs2_addr  <= '0;
      rvfi_rs3_addr  <= '0;
      rvfi_rd_addr   <= '0;
      rvfi_rs1_rdata <= '0;
      rvfi_rs2_rdata <= '0;
      rvfi_rs3_rdata <= '0;
      rvfi_rd_wdata  <= '0;
      rvfi_pc_rdata  <= '0;
      rvfi_pc_wdata  <= '0;
      rvfi_mem_addr  <= '0;
      rvfi_mem_wdata <= '0;
      rvfi_mem_rdata <= '0;
      rvfi_mem_rmask <= '0;
      rvfi_mem_wmask <= '0;
      err_overflow   <= 1'b0;
      err_underflow  <= 1'b0;
    end else begin
      rvfi_valid <= do_pop;
      if (do_pop) begin
        // order_cnt is the index the next packet will carry.
        rvfi_order     <= order_cnt;
        order_cnt      <= order_cnt + 64'd1;
        rvfi_insn      <= buf_insn[rd_ptr];
        rvfi_pc_rdata  <= buf_pc[rd_ptr];
        rvfi_rs1_addr  <= buf_rs1_a[rd_ptr];
        rvfi_rs2_addr  <= buf_rs2_a[rd_ptr];
        rvfi_rs3_addr  <= buf_rs3_a[rd_ptr];
        rvfi_rs1_rdata <= buf_rs1_d[rd_ptr];
        rvfi_rs2_rdata <= buf_rs2_d[rd_ptr];
        rvfi_rs3_rdata <= buf_rs3_d[rd_ptr];
        rvfi_trap      <= ret_trap;
        rvfi_intr      <= ret_intr;
        rvfi_rd_addr   <= ret_rd_addr;
        // x0 is never written architecturally.
        rvfi_rd_wdata  <= (ret_rd_addr == 5'd0) ? '0 : ret_rd_wdata;
        rvfi_pc_wdata  <= ret_pc_wdata;
        rvfi_mem_addr  <= ret_mem_addr;
        rvfi_mem_wdata <= ret_mem_wdata;
        rvfi_mem_rdata <= ret_mem_rdata;
        rvfi_mem_rmask <= ret_mem_rmask;
        rvfi_mem_wmask <= ret_mem_wmask;
      end
      if (overflow_evt)  err_overflow  <= 1'b1;
      if (underflow_evt) err_underflow <= 1'b1;
    end
  end

  assign rvfi_halt = 1'b0;

endmodule

// File: tb/tb_rvfi_trace_gen.sv
// tb/tb_rvfi_trace_gen.sv - self-checking bench for rvfi_trace_gen
module tb_rvfi_trace_gen;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int PW = 32 + XLEN + 15 + 3*XLEN + 5 + 2*XLEN + 2 + 3*XLEN + 2*(XLEN/8);
  localparam logic [31:0] INSN_SHA256_S1 = 32'h0e10702b;

  logic              g_clk = 1'b0;
  logic              g_resetn;
  logic              iss_valid;
  logic [XLEN-1:0]   iss_pc;
  logic [31:0]       iss_insn;
  logic [4:0]        iss_rs1_addr, iss_rs2_addr, iss_rs3_addr;
  logic [XLEN-1:0]   iss_rs1_rdata, iss_rs2_rdata, iss_rs3_rdata;
  logic              ret_valid, ret_trap, ret_intr;
  logic [4:0]        ret_rd_addr;
  logic [XLEN-1:0]   ret_rd_wdata, ret_pc_wdata, ret_mem_addr, ret_mem_wdata, ret_mem_rdata;
  logic [XLEN/8-1:0] ret_mem_rmask, ret_mem_wmask;
  logic              flush;
  logic              rvfi_valid;
  logic [63:0]       rvfi_order;
  logic [31:0]       rvfi_insn;
  logic              rvfi_trap, rvfi_intr, rvfi_halt;
  logic [4:0]        rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs3_addr, rvfi_rd_addr;
  logic [XLEN-1:0]   rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rs3_rdata, rvfi_rd_wdata;
  logic [XLEN-1:0]   rvfi_pc_rdata, rvfi_pc_wdata;
  logic [XLEN-1:0]   rvfi_mem_addr, rvfi_mem_wdata, rvfi_mem_rdata;
  logic [XLEN/8-1:0] rvfi_mem_rmask, rvfi_mem_wmask;
  logic              err_overflow, err_underflow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc, insn;
    logic [4:0]  a1, a2, a3;
    logic [31:0] d1, d2, d3;
  } ent_t;

  ent_t          q[$];
  logic          exp_valid, exp_of, exp_uf;
  logic [63:0]   exp_order, next_ord;
  logic [PW-1:0] exp_pkt;

  rvfi_trace_gen #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .iss_valid(iss_valid), .iss_pc(iss_pc), .iss_insn(iss_insn),
    .iss_rs1_addr(iss_rs1_addr), .iss_rs2_addr(iss_rs2_addr), .iss_rs3_addr(iss_rs3_addr),
    .iss_rs1_rdata(iss_rs1_rdata), .iss_rs2_rdata(iss_rs2_rdata), .iss_rs3_rdata(iss_rs3_rdata),
    .ret_valid(ret_valid), .ret_trap(ret_trap), .ret_intr(ret_intr),
    .ret_rd_addr(ret_rd_addr), .ret_rd_wdata(ret_rd_wdata), .ret_pc_wdata(ret_pc_wdata),
    .ret_mem_addr(ret_mem_addr), .ret_mem_wdata(ret_mem_wdata), .ret_mem_rdata(ret_mem_rdata),
    .ret_mem_rmask(ret_mem_rmask), .ret_mem_wmask(ret_mem_wmask),
    .flush(flush),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_trap(rvfi_trap), .rvfi_intr(rvfi_intr), .rvfi_halt(rvfi_halt),
    .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
    .rvfi_rs3_addr(rvfi_rs3_addr), .rvfi_rd_addr(rvfi_rd_addr),
    .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
    .rvfi_rs3_rdata(rvfi_rs3_rdata), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_wdata(rvfi_mem_wdata),
    .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_rmask(rvfi_mem_rmask),
    .rvfi_mem_wmask(rvfi_mem_wmask),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 g_clk = ~g_clk;

  function automatic logic [PW-1:0] act_pkt();
    return {rvfi_insn, rvfi_pc_rdata, rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs3_addr,
            rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rs3_rdata, rvfi_rd_addr, rvfi_rd_wdata,
            rvfi_pc_wdata, rvfi_trap, rvfi_intr, rvfi_mem_addr, rvfi_mem_wdata,
            rvfi_mem_rdata, rvfi_mem_rmask, rvfi_mem_wmask};
  endfunction

  task automatic model_reset();
    q.delete();
    exp_valid = 1'b0;
    exp_of    = 1'b0;
    exp_uf    = 1'b0;
    exp_order = '0;
    next_ord  = '0;
    exp_pkt   = '0;
  endtask

  // Reference behaviour for one clock: retire, then flush, then issue.
  task automatic model_cycle();
    ent_t        e;
    logic [31:0] wd;
    exp_valid = 1'b0;
    if (ret_valid) begin
      if (q.size() > 0) begin
        e  = q.pop_front();
        wd = (ret_rd_addr == 5'd0) ? 32'd0 : ret_rd_wdata;
        exp_pkt = {e.insn, e.pc, e.a1, e.a2, e.a3, e.d1, e.d2, e.d3, ret_rd_addr, wd,
                   ret_pc_wdata, ret_trap, ret_intr, ret_mem_addr, ret_mem_wdata,
                   ret_mem_rdata, ret_mem_rmask, ret_mem_wmask};
        exp_valid = 1'b1;
        exp_order = next_ord;
        next_ord  = next_ord + 64'd1;
      end else begin
        exp_uf = 1'b1;
      end
    end
    if (flush) q.delete();
    if (iss_valid) begin
      if (q.size() < DEPTH) begin
        e.pc = iss_pc; e.insn = iss_insn;
        e.a1 = iss_rs1_addr; e.a2 = iss_rs2_addr; e.a3 = iss_rs3_addr;
        e.d1 = iss_rs1_rdata; e.d2 = iss_rs2_rdata; e.d3 = iss_rs3_rdata;
        q.push_back(e);
      end else begin
        exp_of = 1'b1;
      end
    end
  endtask

  task automatic rnd_fields();
    iss_pc        = $urandom & 32'hffff_fffc;
    iss_insn      = $urandom;
    iss_rs1_addr  = 5'($urandom_range(0, 31));
    iss_rs2_addr  = 5'($urandom_range(0, 31));
    iss_rs3_addr  = 5'($urandom_range(0, 31));
    iss_rs1_rdata = $urandom;
    iss_rs2_rdata = $urandom;
    iss_rs3_rdata = $urandom;
    ret_trap      = 1'($urandom_range(0, 1));
    ret_intr      = 1'($urandom_range(0, 1));
    ret_rd_addr   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    ret_rd_wdata  = $urandom;
    ret_pc_wdata  = $urandom;
    ret_mem_addr  = $urandom;
    ret_mem_wdata = $urandom;
    ret_mem_rdata = $urandom;
    ret_mem_rmask = 4'($urandom);
    ret_mem_wmask = 4'($urandom);
  endtask

  task automatic cyc(input logic iv, input logic rv, input logic fl);
    iss_valid = iv;
    ret_valid = rv;
    flush     = fl;
    model_cycle();
    @(posedge g_clk);
    #1;
    iss_valid = 1'b0;
    ret_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic do_reset();
    g_resetn = 1'b0;
    model_reset();
    @(posedge g_clk);
    #1;
    g_resetn = 1'b1;
  endtask

  task automatic test_reset();
    total++; if (act_pkt() !== '0) begin bad++; $display("FAIL reset_pkt: got %h want 0", act_pkt()); end
    total++; if ({rvfi_valid, rvfi_halt} !== 2'b00) begin bad++; $display("FAIL reset_valid_halt: got %b want 00", {rvfi_valid, rvfi_halt}); end
    total++; if (rvfi_order !== 64'd0) begin bad++; $display("FAIL reset_order: got %0d want 0", rvfi_order); end
    total++; if ({err_overflow, err_underflow} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {err_overflow, err_underflow}); end
  endtask

  task automatic test_basic();
    rnd_fields();
    iss_pc = 32'h8000_0000; iss_insn = INSN_SHA256_S1; iss_rs1_rdata = 32'h0000_0001;
    cyc(1'b1, 1'b0, 1'b0);
    total++; if (rvfi_valid !== 1'b0) begin bad++; $display("FAIL basic_no_early: got %b want 0", rvfi_valid); end
    rnd_fields();
    ret_rd_addr = 5'd5; ret_rd_wdata = 32'h0000_a000;
    cyc(1'b0, 1'b1, 1'b0);
    total++; if (rvfi_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", rvfi_valid); end
    total++; if (rvfi_order !== 64'd0) begin bad++; $display("FAIL basic_order: got %0d want 0", rvfi_order); end
    total++; if (rvfi_rs1_rdata !== 32'h1) begin bad++; $display("FAIL basic_rs1: got %h want 00000001", rvfi_rs1_rdata); end
    total++; if (rvfi_rd_wdata !== 32'ha000) begin bad++; $display("FAIL basic_rd_wdata: got %h want 0000a000", rvfi_rd_wdata); end
    total++; if (rvfi_pc_rdata !== 32'h8000_0000) begin bad++; $display("FAIL basic_pc: got %h want 80000000", rvfi_pc_rdata); end
    total++; if (rvfi_insn !== INSN_SHA256_S1) begin bad++; $display("FAIL basic_insn: got %h want %h", rvfi_insn, INSN_SHA256_S1); end
    total++; if (act_pkt() !== exp_pkt) begin bad++; $display("FAIL basic_pkt: got %h want %h", act_pkt(), exp_pkt); end
    cyc(1'b0, 1'b0, 1'b0);
    total++; if (rvfi_valid !== 1'b0) begin bad++; $display("FAIL basic_one_shot: got %b want 0", rvfi_valid); end
    total++; if (act_pkt() !== exp_pkt) begin bad++; $display("FAIL basic_hold: got %h want %h", act_pkt(), exp_pkt); end
  endtask

  task automatic test_x0();
    rnd_fields();
    cyc(1'b1, 1'b0, 1'b0);
    rnd_fields();
    ret_rd_addr = 5'd0; ret_rd_wdata = 32'h1234_5678;
    cyc(1'b0, 1'b1, 1'b0);
    total++; if (rvfi_rd_wdata !== 32'd0) begin bad++; $display("FAIL x0_wdata: got %h want 0", rvfi_rd_wdata); end
    total++; if (rvfi_rd_addr !== 5'd0) begin bad++; $display("FAIL x0_addr: got %0d want 0", rvfi_rd_addr); end
    total++; if (rvfi_order !== 64'd1) begin bad++; $display("FAIL x0_order: got %0d want 1", rvfi_order); end
  endtask

  task automatic test_fill_wrap();
    do_reset();
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < DEPTH; i++) begin rnd_fields(); cyc(1'b1, 1'b0, 1'b0); end
      for (int i = 0; i < DEPTH; i++) begin
        rnd_fields();
        cyc(1'b0, 1'b1, 1'b0);
        total++; if (rvfi_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid: got %b want 1", rvfi_valid); end
        total++; if (rvfi_order !== 64'(rep*DEPTH + i)) begin bad++; $display("FAIL wrap_order: got %0d want %0d", rvfi_order, rep*DEPTH + i); end
        total++; if (act_pkt() !== exp_pkt) begin bad++; $display("FAIL wrap_pkt: got %h want %h", act_pkt(), exp_pkt); end
      end
    end
    total++; if ({err_overflow, err_underflow} !== 2'b00) begin bad++; $display("FAIL wrap_flags: got %b want 00", {err_overflow, err_underflow}); end
  endtask

  task automatic test_overflow();
    logic [31:0] pcs[5];
    do_reset();
    for (int i = 0; i < 5; i++) begin
      rnd_fields();
      pcs[i] = iss_pc;
      cyc(1'b1, 1'b0, 1'b0);
      if (i == 3) begin
        total++; if (err_overflow !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", err_overflow); end
      end
    end
    total++; if (err_overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", err_overflow); end
    for (int i = 0; i < 4; i++) begin
      rnd_fields();
      cyc(1'b0, 1'b1, 1'b0);
      total++; if (rvfi_pc_rdata !== pcs[i]) begin bad++; $display("FAIL ovf_pc%0d: got %h want %h", i, rvfi_pc_rdata, pcs[i]); end
      total++; if (act_pkt() !== exp_pkt) begin bad++; $display("FAIL ovf_pkt: got %h want %h", act_pkt(), exp_pkt); end
    end
    rnd_fields();
    cyc(1'b0, 1'b1, 1'b0);
    total++; if ({rvfi_valid, err_underflow} !== 2'b01) begin bad++; $display("FAIL ovf_dropped: got valid/uf %b want 01", {rvfi_valid, err_underflow}); end
  endtask

  task automatic test_flush();
    logic [31:0] pcs[3];
    do_reset();
    for (int i = 0; i < 3; i++) begin rnd_fields(); pcs[i] = iss_pc; cyc(1'b1, 1'b0, 1'b0); end
    rnd_fields();
    iss_pc = 32'h100;
    cyc(1'b1, 1'b1, 1'b1);
    total++; if ({rvfi_valid, rvfi_pc_rdata} !== {1'b1, pcs[0]}) begin bad++; $display("FAIL flush_oldest: got %b/%h want 1/%h", rvfi_valid, rvfi_pc_rdata, pcs[0]); end
    rnd_fields();
    cyc(1'b0, 1'b1, 1'b0);
    total++; if (rvfi_pc_rdata !== 32'h100) begin bad++; $display("FAIL flush_target: got %h want 00000100", rvfi_pc_rdata); end
    total++; if (rvfi_order !== 64'd1) begin bad++; $display("FAIL flush_order: got %0d want 1", rvfi_order); end
    total++; if (act_pkt() !== exp_pkt) begin bad++; $display("FAIL flush_pkt: got %h want %h", act_pkt(), exp_pkt); end
    rnd_fields();
    cyc(1'b0, 1'b1, 1'b0);
    total++; if ({rvfi_valid, err_underflow} !== 2'b01) begin bad++; $display("FAIL flush_count1: got valid/uf %b want 01", {rvfi_valid, err_underflow}); end
  endtask

  task automatic test_underflow_reset();
    do_reset();
    rnd_fields();
    cyc(1'b0, 1'b1, 1'b0);
    total++; if ({rvfi_valid, err_underflow} !== 2'b01) begin bad++; $display("FAIL uf_set: got valid/uf %b want 01", {rvfi_valid, err_underflow}); end
    total++; if (rvfi_order !== 64'd0) begin bad++; $display("FAIL uf_order: got %0d want 0", rvfi_order); end
    for (int i = 0; i < 4; i++) begin rnd_fields(); cyc(1'b1, 1'b0, 1'b0); end
    for (int i = 0; i < 2; i++) begin rnd_fields(); cyc(1'b0, 1'b1, 1'b0); end
    total++; if (rvfi_order !== 64'd1) begin bad++; $display("FAIL uf_pre_order: got %0d want 1", rvfi_order); end
    g_resetn = 1'b0;
    model_reset();
    #2;
    total++; if ({rvfi_valid, err_overflow, err_underflow} !== 3'b000) begin bad++; $display("FAIL async_flags: got %b want 000", {rvfi_valid, err_overflow, err_underflow}); end
    total++; if (rvfi_order !== 64'd0) begin bad++; $display("FAIL async_order: got %0d want 0", rvfi_order); end
    @(posedge g_clk);
    #1;
    g_resetn = 1'b1;
    rnd_fields();
    cyc(1'b0, 1'b1, 1'b0);
    total++; if ({rvfi_valid, err_underflow} !== 2'b01) begin bad++; $display("FAIL reset_discard: got valid/uf %b want 01", {rvfi_valid, err_underflow}); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rnd_fields();
      cyc(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 5), 1'($urandom_range(0, 19) == 0));
      total++; if (rvfi_valid !== exp_valid) begin bad++; $display("FAIL rnd_valid@%0d: got %b want %b", n, rvfi_valid, exp_valid); end
      total++; if (rvfi_order !== exp_order) begin bad++; $display("FAIL rnd_order@%0d: got %0d want %0d", n, rvfi_order, exp_order); end
      total++; if (act_pkt() !== exp_pkt) begin bad++; $display("FAIL rnd_pkt@%0d: got %h want %h", n, act_pkt(), exp_pkt); end
      total++; if ({err_overflow, err_underflow} !== {exp_of, exp_uf}) begin bad++; $display("FAIL rnd_flags@%0d: got %b want %b", n, {err_overflow, err_underflow}, {exp_of, exp_uf}); end
      total++; if (rvfi_halt !== 1'b0) begin bad++; $display("FAIL rnd_halt@%0d: got %b want 0", n, rvfi_halt); end
    end
  endtask

  initial begin
    g_resetn  = 1'b0;
    iss_valid = 1'b0;
    ret_valid = 1'b0;
    flush     = 1'b0;
    iss_pc = '0; iss_insn = '0;
    iss_rs1_addr = '0; iss_rs2_addr = '0; iss_rs3_addr = '0;
    iss_rs1_rdata = '0; iss_rs2_rdata = '0; iss_rs3_rdata = '0;
    ret_trap = 1'b0; ret_intr = 1'b0; ret_rd_addr = '0; ret_rd_wdata = '0;
    ret_pc_wdata = '0; ret_mem_addr = '0; ret_mem_wdata = '0; ret_mem_rdata = '0;
    ret_mem_rmask = '0; ret_mem_wmask = '0;
    model_reset();
    repeat (2) @(posedge g_clk);
    #1;
    g_resetn = 1'b1;
    test_reset();
    test_basic();
    test_x0();
    test_fill_wrap();
    test_overflow();
    test_flush();
    test_underflow_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
